// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - tap sequencer for a time-multiplexed FIR MAC
// Optional delay-line flush is enabled by defining FIR_FLUSH_EN.
module fir_tap_sequencer #(
  parameter int NTAPS  = 64,
  parameter int ADDR_W = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef FIR_FLUSH_EN
  input  logic              flush,
  output logic              smp_zero,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  output logic              smp_we,
  output logic [ADDR_W-1:0] smp_waddr,
  output logic [ADDR_W-1:0] smp_raddr,
  output logic [ADDR_W-1:0] coef_raddr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cfg_we,
  output logic              cfg_ready,
  output logic              coef_we,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, DONE
`ifdef FIR_FLUSH_EN
    , FLUSH
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NTAPS - 1);
  localparam logic [ADDR_W:0]   NTAPS_W = (ADDR_W + 1)'(NTAPS);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] tap;
  logic [ADDR_W-1:0] rd_addr;
  logic              flush_req;
  logic              accept;

`ifdef FIR_FLUSH_EN
  assign flush_req = flush;
  assign smp_zero  = (state == FLUSH);
`else
  assign flush_req = 1'b0;
`endif

  // Newest sample sits at wr_ptr; tap k reads k samples back, wrapping without relying on 2^n sizes.
  always_comb begin
    if (tap > wr_ptr)
      rd_addr = ADDR_W'(NTAPS_W + {1'b0, wr_ptr} - {1'b0, tap});
    else
      rd_addr = wr_ptr - tap;
  end

  always_comb begin
    in_ready   = 1'b0;
    cfg_ready  = 1'b0;
    smp_we     = 1'b0;
    smp_waddr  = wr_ptr;
    smp_raddr  = '0;
    coef_raddr = '0;
    acc_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          cfg_ready = ~flush_req;
          in_ready  = ~flush_req & ~cfg_we;
        end
        smp_we  = in_valid & in_ready;
        acc_clr = in_valid & in_ready;
      end
      RUN: begin
        smp_raddr  = rd_addr;
        coef_raddr = tap;
      end
`ifdef FIR_FLUSH_EN
      FLUSH: begin
        smp_we    = 1'b1;
        smp_waddr = tap;
      end
`endif
      default: ;
    endcase
  end

  assign accept    = (state == IDLE) & in_valid & in_ready;
  assign coef_we   = cfg_we & cfg_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      tap    <= '0;
      acc_en <= 1'b0;
    end else begin
      // RAM read data arrives one cycle after the RUN address.
      acc_en <= (state == RUN);
      case (state)
        IDLE: begin
          if (flush_req) begin
`ifdef FIR_FLUSH_EN
            state <= FLUSH;
`endif
            tap   <= '0;
          end else if (accept) begin
            state <= RUN;
            tap   <= '0;
          end
        end
        RUN: begin
          if (tap == LAST) state <= DRAIN;
          else             tap   <= tap + ADDR_W'(1);
        end
        DRAIN: begin
          wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + ADDR_W'(1);
          state  <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
`ifdef FIR_FLUSH_EN
        FLUSH: begin
          if (tap == LAST) begin
            wr_ptr <= '0;
            tap    <= '0;
            state  <= IDLE;
          end else begin
            tap <= tap + ADDR_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - scoreboard bench for fir_tap_sequencer, NTAPS=4
// Exercises the FIR_FLUSH_EN path when that macro is defined.
module tb_fir_tap_sequencer;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          cfg_we = 1'b0;
  logic          in_ready, smp_we, acc_clr, acc_en, out_valid, cfg_ready, coef_we, busy;
  logic [AW-1:0] smp_waddr, smp_raddr, coef_raddr;
  logic          smp_zero;
`ifdef FIR_FLUSH_EN
  logic          flush = 1'b0;
`else
  assign smp_zero = 1'b0;
`endif

  fir_tap_sequencer #(.NTAPS(N)) dut (
    .clk(clk), .reset(reset),
`ifdef FIR_FLUSH_EN
    .flush(flush), .smp_zero(smp_zero),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .smp_we(smp_we),
    .smp_waddr(smp_waddr), .smp_raddr(smp_raddr), .coef_raddr(coef_raddr),
    .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .coef_we(coef_we), .busy(busy)
  );

  always #5 clk = ~clk;

  int                  total = 0;
  int                  bad = 0;
  int                  cyc = 0;
  int                  acc_cyc = 0;
  int                  prev_acc_cyc = 0;
  logic [15:0]         cur_sample = 16'h8000;
  logic [AW-1:0]       cfg_addr = '0;
  logic signed [15:0]  cfg_data = '0;
  logic [15:0]         smem [N];
  logic signed [15:0]  cmem [N];
  longint              acc = 0;
  logic [AW-1:0]       sr_q = '0;
  logic [AW-1:0]       cr_q = '0;
  logic [2:0]          wq [$];
  logic [3:0]          rq [$];
  longint              yq [$];
  logic [2:0]          we_exp;
  logic [3:0]          re_exp;
  longint              y_exp;
  logic                prev_hs = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // External RAMs and MAC as the surrounding datapath would build them.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (acc_clr) acc = 0;
    else if (acc_en) acc = acc + longint'(int'(smem[sr_q]) - 32768) * longint'(cmem[cr_q]);
    sr_q = smp_raddr;
    cr_q = coef_raddr;
    if (smp_we) smem[smp_waddr] = smp_zero ? 16'h8000 : cur_sample;
    if (coef_we) cmem[cfg_addr] = cfg_data;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (smp_we) begin
        if (wq.size() == 0) check("unexpected_write", 1, 0);
        else begin
          we_exp = wq.pop_front();
          check("waddr", {smp_zero, smp_waddr}, we_exp);
        end
      end
      if (acc_en) begin
        if (rq.size() == 0) check("unexpected_acc_en", 1, 0);
        else begin
          re_exp = rq.pop_front();
          check("read_addr", {sr_q, cr_q}, re_exp);
        end
      end
      if (prev_hs) check("out_valid_pulse", out_valid, 0);
      if (out_valid && out_ready) begin
        if (yq.size() == 0) check("unexpected_result", 1, 0);
        else begin
          y_exp = yq.pop_front();
          check("result", acc, y_exp);
        end
      end
      prev_hs = out_valid && out_ready;
    end else begin
      prev_hs = 1'b0;
    end
  end

  task automatic issue(input int x, input int wa, input longint y);
    wq.push_back({1'b0, 2'(wa)});
    for (int k = 0; k < N; k++) rq.push_back({2'((wa + N - k) % N), 2'(k)});
    yq.push_back(y);
    cur_sample = 16'(32768 + x);
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_accept_in_time"}, longint'(n < 100), 1);
    prev_acc_cyc = acc_cyc;
    acc_cyc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((yq.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, longint'(n < 200), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    for (int i = 0; i < N; i++) begin
      smem[i] = 16'h8000;
      cmem[i] = '0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_strobes", {in_ready, cfg_ready, busy, smp_we, acc_en, out_valid, coef_we, acc_clr}, 0);
    check("reset_addrs", {smp_waddr, smp_raddr, coef_raddr}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // abort a run at tap 2
    issue(7, 0, 0);
    wait_accept("abort");
    @(posedge clk);
    @(posedge clk);
    #2;
    check("abort_pre_acc_en", acc_en, 1);
    reset = 1'b1;
    wq.delete();
    rq.delete();
    yq.delete();
    #1;
    check("abort_acc_en", acc_en, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // configuration wins over a simultaneous sample
    issue(1, 0, 1);
    cfg_we = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = 16'sd1;
    @(negedge clk);
    check("arb_coef_we", coef_we, 1);
    check("arb_in_ready", in_ready, 0);
    for (int i = 1; i < N; i++) begin
      @(posedge clk);
      #1 cfg_addr = 2'(i);
      cfg_data = 16'(i + 1);
    end
    @(posedge clk);
    #1 cfg_we = 1'b0;
    @(negedge clk);
    check("arb_accept_next", in_ready, 1);
    check("first_waddr", smp_waddr, 0);
    check("first_acc_clr", acc_clr, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;

    // configuration attempt during RUN is ignored; latency to out_valid
    cfg_we = 1'b1;
    cfg_addr = 2'd3;
    cfg_data = 16'sd99;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (lat == 1) begin
        check("run_coef_we", coef_we, 0);
        check("run_cfg_ready", cfg_ready, 0);
        cfg_we = 1'b0;
      end
      if (out_valid) break;
    end
    check("latency", lat, 6);
    @(posedge clk);
    #1;

    // back-to-back samples, wrapping the write pointer
    begin
      int xs [4] = '{2, 3, 4, 5};
      int was [4] = '{1, 2, 3, 0};
      longint ys [4] = '{4, 10, 20, 30};
      for (int i = 0; i < 4; i++) begin
        issue(xs[i], was[i], ys[i]);
        wait_accept("b2b");
        check("throughput", acc_cyc - prev_acc_cyc, 7);
      end
    end
    wait_drain("b2b");

    // backpressure with the next sample already waiting
    out_ready = 1'b0;
    issue(6, 1, 40);
    wait_accept("bp6");
    issue(7, 2, 50);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready}, 2'b10);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drain("bp");

`ifdef FIR_FLUSH_EN
    flush = 1'b1;
    for (int a = 0; a < N; a++) wq.push_back({1'b1, 2'(a)});
    @(negedge clk);
    check("flush_req_ready", {in_ready, cfg_ready}, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    wait_drain("flush");
    issue(1, 0, 1);
    wait_accept("imp0");
    issue(0, 1, 2);
    wait_accept("imp1");
    issue(0, 2, 3);
    wait_accept("imp2");
    issue(0, 3, 4);
    wait_accept("imp3");
    wait_drain("impulse");
`endif

    check("queues_empty", wq.size() + rq.size() + yq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
